frac_encode: RTL

- Producer end of the fractional-time channel: one instance per TDC counter, in that counter's clock domain.
- Captures the tapped-delay-line thermometer code on a stop hit, removes single-tap bubbles and converts it to a 7-bit fine count.
- Presents the count with a one-cycle write strobe that drives one lane of the fraction synchroniser's in_data/in_wr inputs.
- Also enforces a dead time after each hit and counts hits lost to it.

---
 rtl/frac_pkg.sv | 16 +
 rtl/therm_popcount.sv | 71 +++++++
 rtl/frac_encode.sv | 122 ++++++++++++
 3 files changed

// File: rtl/frac_pkg.sv
// Shared definitions for the fractional-time channel.
// FRAC_W : width of a fine count (fits a 127-tap delay line).
// frac_t : fine-count type, also used by the synchroniser lanes.
// state_t: capture / dead-time state of the encoder.
package frac_pkg;

  localparam int FRAC_W = 7;

  typedef logic [FRAC_W-1:0] frac_t;

  typedef enum logic {
    ST_IDLE,
    ST_DEAD
  } state_t;

endpackage

// File: rtl/therm_popcount.sv
// Registered bubble-correction and population-count stage pair.
// Stage A: 3-input majority across neighbouring taps removes single-tap
//          bubbles (tap -1 is treated as 1, tap TAPS as 0).
// Stage B: population count of the corrected code.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   in_valid  : therm holds a freshly captured code
//   therm     : captured thermometer code, TAPS bits
//   out_valid : count is new this cycle (two clocks after in_valid)
//   count     : fine count of the corrected code
module therm_popcount
  import frac_pkg::*;
#(
  parameter int TAPS = 127
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [TAPS-1:0] therm,
  output logic            out_valid,
  output frac_t           count
);

  // Pad with the fixed boundary values so every tap sees two neighbours.
  logic [TAPS+1:0] ext;
  assign ext = {1'b0, therm, 1'b1};

  logic [TAPS-1:0] maj_next;
  logic [TAPS-1:0] maj_reg;
  logic            maj_valid_reg;
  frac_t           count_next;
  frac_t           count_reg;
  logic            count_valid_reg;

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_maj
      assign maj_next[gi] = (ext[gi]   & ext[gi+1]) |
                            (ext[gi]   & ext[gi+2]) |
                            (ext[gi+1] & ext[gi+2]);
    end
  endgenerate

  always_comb begin
    count_next = '0;
    for (int i = 0; i < TAPS; i++) begin
      count_next = count_next + frac_t'(maj_reg[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      maj_reg         <= '0;
      maj_valid_reg   <= 1'b0;
      count_reg       <= '0;
      count_valid_reg <= 1'b0;
    end else begin
      maj_valid_reg   <= in_valid;
      count_valid_reg <= maj_valid_reg;
      if (in_valid) begin
        maj_reg <= maj_next;
      end
      if (maj_valid_reg) begin
        count_reg <= count_next;
      end
    end
  end

  assign out_valid = count_valid_reg;
  assign count     = count_reg;

endmodule

// File: rtl/frac_encode.sv
// Fine-time encoder for one TDC lane.
// Captures the delay-line taps on a rising hit, corrects bubbles, converts
// to a 7-bit count and presents it with a one-cycle write strobe, four
// clocks after capture. A dead time follows each accepted hit; hits that
// arrive during it are counted (saturating) and otherwise ignored.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   taps     : raw delay-line taps, tap 0 nearest the hit origin
//   hit      : stop event level, synchronous to clk
//   out_data : fine count, held until the next conversion
//   out_wr   : one-cycle strobe marking a new out_data
//   busy     : high outside the idle state
//   dropped  : saturating count of hits rejected while busy
module frac_encode
  import frac_pkg::*;
#(
  parameter int TAPS     = 127,
  parameter int DEAD_CYC = 8,
  parameter int DROP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAPS-1:0]   taps,
  input  logic              hit,
  output frac_t             out_data,
  output logic              out_wr,
  output logic              busy,
  output logic [DROP_W-1:0] dropped
);

  localparam int CNT_W = $clog2(DEAD_CYC);

  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W-1:0]    dead_cnt_reg;
  logic [CNT_W-1:0]    dead_cnt_next;
  logic [DROP_W-1:0]   dropped_reg;
  logic [DROP_W-1:0]   dropped_next;
  logic                hit_q;
  logic                hit_edge;
  logic                capture;
  logic [TAPS-1:0]     taps_reg;
  logic                taps_valid_reg;
  logic                count_valid;
  frac_t               count;
  frac_t               out_data_reg;
  logic                out_wr_reg;

  // A hit held high is one event: only the rising edge matters.
  assign hit_edge = hit & ~hit_q;

  always_comb begin
    state_next    = state_reg;
    dead_cnt_next = dead_cnt_reg;
    dropped_next  = dropped_reg;
    capture       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hit_edge) begin
          capture       = 1'b1;
          dead_cnt_next = CNT_W'(DEAD_CYC - 1);
          state_next    = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          dead_cnt_next = dead_cnt_reg - 1'b1;
        end
        // Includes the edge coinciding with the return to idle.
        if (hit_edge && (dropped_reg != {DROP_W{1'b1}})) begin
          dropped_next = dropped_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      dead_cnt_reg   <= '0;
      dropped_reg    <= '0;
      hit_q          <= 1'b0;
      taps_reg       <= '0;
      taps_valid_reg <= 1'b0;
      out_data_reg   <= '0;
      out_wr_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dead_cnt_reg   <= dead_cnt_next;
      dropped_reg    <= dropped_next;
      hit_q          <= hit;
      taps_valid_reg <= capture;
      if (capture) begin
        taps_reg <= taps;
      end
      out_wr_reg <= count_valid;
      if (count_valid) begin
        out_data_reg <= count;
      end
    end
  end

  therm_popcount #(
    .TAPS(TAPS)
  ) u_popcount (
    .clk      (clk),
    .rst      (rst),
    .in_valid (taps_valid_reg),
    .therm    (taps_reg),
    .out_valid(count_valid),
    .count    (count)
  );

  assign out_data = out_data_reg;
  assign out_wr   = out_wr_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign dropped  = dropped_reg;

endmodule
